// File: rtl/execute_unit.sv
// Execute stage: operand forwarding, ARM condition check, ALU, NZCV flag register.
// Define EXECUTE_UNIT_MUL_EN to build the iterative shift-add multiplier and its stall FSM.
//
// Multiplier FSM states:
//   state | meaning
//   IDLE  | no multiply in flight; a conditioned-true MUL starts here and stalls
//   BUSY  | one shift-add step per cycle, SIZE steps, stall held
//   DONE  | product on ALUResultE, gated controls released, back to IDLE
module execute_unit #(
   parameter int SIZE = 32
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            MemToRegE,
   input  logic            PCSrcE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [1:0]      FlagWriteE,
   input  logic [3:0]      ALUControlE,
   input  logic [3:0]      CondE,
   input  logic [SIZE-1:0] RE1,
   input  logic [SIZE-1:0] RE2,
   input  logic [SIZE-1:0] ExtImmE,
   input  logic [4:0]      WA3E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [SIZE-1:0] ResultW,
   input  logic [SIZE-1:0] ALUResultM,
   output logic [SIZE-1:0] ALUResultE,
   output logic [SIZE-1:0] WriteDataE,
   output logic [4:0]      WA3EOut,
   output logic            MemToRegEOut,
   output logic            RegWriteGE,
   output logic            MemWriteGE,
   output logic            PCSrcGE,
   output logic            BranchTakenE,
   output logic [3:0]      FlagsOut,
   output logic            StallE
);

   logic [SIZE-1:0] src_a;
   logic [SIZE-1:0] src_b;
   logic [SIZE-1:0] alu_result;
   logic [SIZE-1:0] mul_result;
   logic [SIZE:0]   sum_ext;
   logic [SIZE:0]   diff_ext;
   logic            alu_c;
   logic            alu_v;
   logic            alu_n;
   logic            alu_z;
   logic            cond_ex;
   logic            is_mul;
   logic            stall;
   logic            flag_n;
   logic            flag_z;
   logic            flag_c;
   logic            flag_v;

   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = RE1;
      endcase
   end

   always_comb begin
      case (ForwardBE)
         2'b01:   WriteDataE = ResultW;
         2'b10:   WriteDataE = ALUResultM;
         default: WriteDataE = RE2;
      endcase
   end

   assign src_b  = ALUSrcE ? ExtImmE : WriteDataE;
   assign is_mul = (ALUControlE == 4'b1000);

   always_comb begin
      cond_ex = 1'b0;
      case (CondE)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Subtraction as A + ~B + 1 so the carry-out is the ARM NOT-borrow.
   assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
   assign diff_ext = {1'b0, src_a} + {1'b0, ~src_b} + {{SIZE{1'b0}}, 1'b1};

   always_comb begin
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (ALUControlE)
         4'b0000: begin
            alu_result = sum_ext[SIZE-1:0];
            alu_c      = sum_ext[SIZE];
            alu_v      = (src_a[SIZE-1] == src_b[SIZE-1]) &&
                         (sum_ext[SIZE-1] != src_a[SIZE-1]);
         end
         4'b0001: begin
            alu_result = diff_ext[SIZE-1:0];
            alu_c      = diff_ext[SIZE];
            alu_v      = (src_a[SIZE-1] != src_b[SIZE-1]) &&
                         (diff_ext[SIZE-1] != src_a[SIZE-1]);
         end
         4'b0010: alu_result = src_a & src_b;
         4'b0011: alu_result = src_a | src_b;
         4'b0100: alu_result = src_a ^ src_b;
         4'b0101: alu_result = src_b;
         4'b0110: alu_result = src_a << src_b[4:0];
         4'b0111: alu_result = src_a >> src_b[4:0];
         4'b1000: alu_result = mul_result;
         default: alu_result = '0;
      endcase
   end

   assign alu_n = alu_result[SIZE-1];
   assign alu_z = (alu_result == '0);

`ifdef EXECUTE_UNIT_MUL_EN
   localparam int CW = $clog2(SIZE);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_t;

   mul_state_t      state;
   mul_state_t      state_nxt;
   logic [CW-1:0]   cnt;
   logic [SIZE-1:0] mcand;
   logic [SIZE-1:0] mplier;
   logic [SIZE-1:0] product;
   logic            mul_start;
   logic            mul_valid;

   // Held off while RSTN is low so a MUL still on the inputs cannot stall during reset.
   assign mul_start = is_mul & cond_ex & RSTN;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state   <= IDLE;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (mul_start) begin
                  mcand   <= src_a;
                  mplier  <= src_b;
                  product <= '0;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               if (mplier[0]) product <= product + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      mul_valid = 1'b0;
      case (state)
         IDLE: begin
            if (mul_start) begin
               state_nxt = BUSY;
               stall     = 1'b1;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt == CW'(SIZE - 1)) state_nxt = DONE;
         end
         DONE: begin
            mul_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mul_result = mul_valid ? product : '0;
`else
   assign stall      = 1'b0;
   assign mul_result = '0;
`endif

   // MUL only ever touches N and Z; C,V are left alone even if bit0 is set.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (cond_ex && !stall) begin
         if (FlagWriteE[1]) begin
            flag_n <= alu_n;
            flag_z <= alu_z;
         end
         if (FlagWriteE[0] && !is_mul) begin
            flag_c <= alu_c;
            flag_v <= alu_v;
         end
      end
   end

   assign ALUResultE   = alu_result;
   assign WA3EOut      = WA3E;
   assign MemToRegEOut = MemToRegE;
   assign RegWriteGE   = RegWriteE & cond_ex & ~stall;
   assign MemWriteGE   = MemWriteE & cond_ex & ~stall;
   assign PCSrcGE      = PCSrcE & cond_ex & ~stall;
   assign BranchTakenE = BranchE & cond_ex & ~stall;
   assign FlagsOut     = {flag_n, flag_z, flag_c, flag_v};
   assign StallE       = stall;

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the pipelined core, sitting directly downstream of the Decode/Execute pipeline register and feeding the Execute/Memory register. It selects forwarded operands, evaluates the ARM-style condition against the architectural NZCV flag register, and performs the ALU operation. It owns the flag register and an optional iterative multiplier that stalls the front of the pipeline while busy. It produces condition-gated write/branch controls for downstream stages.

## Interface
- SIZE, 32, datapath width; multiplier iteration count equals SIZE
- CLK  in  1  clock; all state updates on rising edge
- RSTN  in  1  synchronous reset, active low
- RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE, ALUSrcE  in  1 each  execute-stage controls
- FlagWriteE  in  2  bit1 enables N,Z update; bit0 enables C,V update
- ALUControlE  in  4  operation code
- CondE  in  4  ARM condition code (0000 EQ … 1110 AL)
- RE1, RE2, ExtImmE  in  SIZE  register operands and extended immediate
- WA3E  in  5  destination register
- ForwardAE, ForwardBE  in  2  00 RE1/RE2, 01 ResultW, 10 ALUResultM, 11 treated as 00
- ResultW, ALUResultM  in  SIZE  forwarding sources
- ALUResultE  out  SIZE  operation result
- WriteDataE  out  SIZE  forwarded B operand before immediate mux (store data)
- WA3EOut  out  5  WA3E passthrough
- MemToRegEOut  out  1  MemToRegE passthrough
- RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE  out  1 each  controls ANDed with CondExE and with ~StallE
- FlagsOut  out  4  current NZCV register {N,Z,C,V}
- StallE  out  1  high while multiply is in progress; upstream holds its stages

## Operation
- SrcA = forward mux A; WriteDataE = forward mux B; SrcB = ALUSrcE ? ExtImmE : WriteDataE.
- ALU codes: 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (B), 0110 LSL (A << B[4:0]), 0111 LSR (A >> B[4:0]), 1000 MUL (low SIZE bits of A×B), others → result 0.
- Flags from the op: N = result[SIZE-1], Z = (result == 0); C = carry-out for ADD, NOT-borrow for SUB, else 0; V = signed overflow for ADD/SUB, else 0. All flags compute modulo 2^SIZE.
- CondExE: evaluated from CondE against registered NZCV using standard ARM semantics. Code 1111 evaluates false.
- Flag register updates at the edge only when CondExE=1, StallE=0, and the matching FlagWriteE bit is set. Groups update independently.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - IDLE→BUSY: ALUControlE=1000 and CondExE=1. Operands are captured and the counter is cleared.
  - BUSY: one shift-add step per cycle. After SIZE steps, the FSM moves to DONE.
  - DONE→IDLE unconditionally.
  - A MUL with CondExE=0 does not start the FSM and does not stall.
- StallE = (IDLE and a starting MUL) or BUSY.
- In DONE, ALUResultE = product. The op's gated controls are presented; MUL sets N,Z only, via FlagWriteE bit1.

## Timing
- Non-MUL ops are combinational: result and gated controls are valid in the same cycle as the inputs.
- A MUL presented in cycle t has StallE=1 in cycles t…t+SIZE and the result valid in cycle t+SIZE+1 with StallE=0. Total occupancy is SIZE+2 cycles.
- While StallE=1, upstream holds the DE register contents stable. RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE are all 0, and flags do not update.
- A back-to-back MUL is re-evaluated in IDLE on the cycle after DONE and starts then.
- Reset values: FSM=IDLE, NZCV=0000, counter=0, StallE=0. Combinational outputs follow their inputs.
- A reset during BUSY aborts the multiply: state is IDLE after the edge, StallE=0, and no result is produced.

## Configuration
- EXECUTE_UNIT_MUL_EN: when defined, the iterative multiplier and FSM are compiled in as above.
- When undefined, code 1000 yields ALUResultE=0, StallE is tied to 0, and the FSM is not built.

## Test plan
- Reset with RSTN=0 for 2 cycles → FlagsOut=0000, StallE=0; then ADD 0x7FFFFFFF+1 with FlagWriteE=11, CondE=1110 → result 0x80000000, flags N=1 Z=0 C=0 V=1 after the edge.
- SUB 5−5 with FlagWriteE=11, then next op with CondE=0000 (EQ) and RegWriteE=1 → RegWriteGE=1; the same op with CondE=0001 (NE) → RegWriteGE=0, flags unchanged.
- ForwardAE=10, ALUResultM=0x10, ForwardBE=01, ResultW=0x3, ALUControlE=0001 → ALUResultE=0x0D, WriteDataE=0x3.
- MUL 0x1234×0x10 with the macro defined, SIZE=32 → StallE high for exactly 33 cycles, then ALUResultE=0x12340 with RegWriteGE=1 for one cycle.
- Assert RSTN=0 at cycle 10 of a MUL → StallE=0 the cycle after the edge; no RegWriteGE pulse is produced.
- MUL with the macro undefined → StallE never asserts, ALUResultE=0.
